// File: rtl/sw_debounce_if.sv
// Switch-bank signal bundle: raw pins in, debounced level, edge pulses and busy out.
interface sw_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             busy;

  modport master (output sw_in, input sw_out, rise_pulse, fall_pulse, busy);
  modport slave  (input sw_in, output sw_out, rise_pulse, fall_pulse, busy);
endinterface

// File: rtl/sw_debounce.sv
// Per-bit synchronizer + debouncer for the slide-switch bank, with registered rise/fall pulses.
// Optional SW_DEBOUNCE_TICK_EN: debounce updates only on a shared TICK_DIV prescaler tick.
module sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int TICK_DIV        = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  sw_debounce_if.slave bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 || TICK_DIV < 1 ||
      (CNT_W < 31 && (1 << CNT_W) <= DEBOUNCE_CYCLES)) begin : g_bad_param
    $error("sw_debounce: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sw_sync;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             busy_q;
  logic             busy_c;
  logic             tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sw_sync = sync_q[SYNC_STAGES-1];

`ifdef SW_DEBOUNCE_TICK_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre_q;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= '0;
    else          pre_q <= tick ? '0 : pre_q + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt[i] != '0) busy_c = 1'b1;
    end
  end

  // Any agreeing sample restarts the count; the flip happens on the last disagreeing sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= busy_c;
      if (tick) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sw_sync[i] == sw_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_MAX) begin
            cnt[i]    <= '0;
            sw_q[i]   <= sw_sync[i];
            rise_q[i] <= sw_sync[i];
            fall_q[i] <= ~sw_sync[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.sw_out     = sw_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4; TICK_DIV=8 when SW_DEBOUNCE_TICK_EN).
module tb_sw_debounce;
  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sw_debounce_if #(.WIDTH(10)) bus ();

  sw_debounce #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16), .TICK_DIV(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.sw_in = 10'h000;
    repeat (3) clk_step();
    n_vec++; if (bus.sw_out !== 10'h000) begin n_err++; $display("FAIL reset_sw_out got %h want 000", bus.sw_out); end
    n_vec++; if (bus.rise_pulse !== 10'h000) begin n_err++; $display("FAIL reset_rise got %h want 000", bus.rise_pulse); end
    n_vec++; if (bus.fall_pulse !== 10'h000) begin n_err++; $display("FAIL reset_fall got %h want 000", bus.fall_pulse); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_step;
    logic [9:0] exp_out, exp_rise;
    bus.sw_in = 10'h008;
    for (int e = 1; e <= 8; e++) begin
      clk_step();
      exp_out  = (e >= 6) ? 10'h008 : 10'h000;
      exp_rise = (e == 6) ? 10'h008 : 10'h000;
      n_vec++; if (bus.sw_out !== exp_out) begin n_err++; $display("FAIL step_sw_out edge %0d got %h want %h", e, bus.sw_out, exp_out); end
      n_vec++; if (bus.rise_pulse !== exp_rise) begin n_err++; $display("FAIL step_rise edge %0d got %h want %h", e, bus.rise_pulse, exp_rise); end
      n_vec++; if (bus.fall_pulse !== 10'h000) begin n_err++; $display("FAIL step_fall edge %0d got %h want 000", e, bus.fall_pulse); end
    end
  endtask

  task automatic test_bounce;
    logic [5:0] pat = 6'b101101;
    int rises = 0, falls = 0, first = 0;
    for (int e = 1; e <= 14; e++) begin
      bus.sw_in[0] = (e <= 6) ? pat[e-1] : 1'b1;
      clk_step();
      if (bus.rise_pulse[0]) begin rises++; if (first == 0) first = e; end
      if (bus.fall_pulse[0]) falls++;
    end
    n_vec++; if (first !== 11) begin n_err++; $display("FAIL bounce_rise_edge got %0d want 11", first); end
    n_vec++; if (rises !== 1) begin n_err++; $display("FAIL bounce_rise_count got %0d want 1", rises); end
    n_vec++; if (falls !== 0) begin n_err++; $display("FAIL bounce_fall_count got %0d want 0", falls); end
    n_vec++; if (bus.sw_out !== 10'h009) begin n_err++; $display("FAIL bounce_sw_out got %h want 009", bus.sw_out); end
  endtask

  task automatic test_glitch;
    int busy_seen = 0, pulses = 0, out_bad = 0;
    for (int e = 1; e <= 12; e++) begin
      bus.sw_in[5] = (e <= 3);
      clk_step();
      if (bus.busy) busy_seen++;
      if (bus.rise_pulse != 10'h000 || bus.fall_pulse != 10'h000) pulses++;
      if (bus.sw_out != 10'h009) out_bad++;
    end
    n_vec++; if (busy_seen !== 3) begin n_err++; $display("FAIL glitch_busy_cycles got %0d want 3", busy_seen); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end got %b want 0", bus.busy); end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    n_vec++; if (out_bad !== 0) begin n_err++; $display("FAIL glitch_sw_out bad cycles %0d want 0", out_bad); end
  endtask

  task automatic test_fall;
    logic [9:0] exp_fall;
    bus.sw_in = 10'h000;
    for (int e = 1; e <= 7; e++) begin
      clk_step();
      exp_fall = (e == 6) ? 10'h009 : 10'h000;
      n_vec++; if (bus.fall_pulse !== exp_fall) begin n_err++; $display("FAIL fall_pulse edge %0d got %h want %h", e, bus.fall_pulse, exp_fall); end
      n_vec++; if (bus.rise_pulse !== 10'h000) begin n_err++; $display("FAIL fall_rise edge %0d got %h want 000", e, bus.rise_pulse); end
    end
    n_vec++; if (bus.sw_out !== 10'h000) begin n_err++; $display("FAIL fall_sw_out got %h want 000", bus.sw_out); end
  endtask

  task automatic test_reset_high;
    logic [9:0] exp_out, exp_rise;
    reset_n = 1'b0;
    bus.sw_in = 10'h3FF;
    repeat (2) clk_step();
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      clk_step();
      exp_out  = (e >= 6) ? 10'h3FF : 10'h000;
      exp_rise = (e == 6) ? 10'h3FF : 10'h000;
      n_vec++; if (bus.sw_out !== exp_out) begin n_err++; $display("FAIL rsthi_sw_out edge %0d got %h want %h", e, bus.sw_out, exp_out); end
      n_vec++; if (bus.rise_pulse !== exp_rise) begin n_err++; $display("FAIL rsthi_rise edge %0d got %h want %h", e, bus.rise_pulse, exp_rise); end
    end
  endtask

  task automatic test_reset_midcount;
    int bad = 0;
    bus.sw_in = 10'h000;
    repeat (4) clk_step();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %b want 1", bus.busy); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (bus.sw_out !== 10'h000) begin n_err++; $display("FAIL mid_sw_out got %h want 000", bus.sw_out); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    n_vec++; if ((bus.rise_pulse | bus.fall_pulse) !== 10'h000) begin n_err++; $display("FAIL mid_pulses got %h want 000", bus.rise_pulse | bus.fall_pulse); end
    clk_step();
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      clk_step();
      if (bus.sw_out != 10'h000 || bus.rise_pulse != 10'h000 || bus.fall_pulse != 10'h000) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mid_after_release bad cycles %0d want 0", bad); end
  endtask

  task automatic test_tick;
    int n = 0;
    bus.sw_in = 10'h200;
    while (n < 100 && bus.sw_out[9] !== 1'b1) begin
      clk_step();
      n++;
    end
    n_vec++; if (n < 27 || n > 34) begin n_err++; $display("FAIL tick_latency got %0d want 27..34", n); end
    n_vec++; if (bus.sw_out !== 10'h200) begin n_err++; $display("FAIL tick_sw_out got %h want 200", bus.sw_out); end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.sw_in = 10'h000;
    test_reset();
`ifdef SW_DEBOUNCE_TICK_EN
    repeat (3) clk_step();
    test_tick();
`else
    test_step();
    test_bounce();
    test_glitch();
    test_fall();
    test_reset_high();
    test_reset_midcount();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
